line_clear_engine: RTL and testbench

//  Sits directly downstream of the pixel-map loader. Takes the 20x10 playfield snapshot
//  (4-bit colour per cell) after a piece touches down. Finds every full row, collapses
//  the rows above it downward, and returns the compacted map. Keeps the running line

---
 rtl/line_clear_engine_if.sv | 26 ++
 rtl/line_clear_engine.sv | 156 +++++++++++++++
 tb/tb_line_clear_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_engine_if.sv
// Handshake and map bus between the pixel-map loader (master) and the
// line clear engine (slave). Also carries the running line/score counters.
interface line_clear_engine_if #(
   parameter int ROWS = 20,
   parameter int COLS = 10,
   parameter int CW   = 4
) ();
   logic                                start;
   logic [ROWS-1:0][COLS-1:0][CW-1:0]   map_in;
   logic                                busy;
   logic                                done;
   logic [ROWS-1:0][COLS-1:0][CW-1:0]   map_out;
   logic [2:0]                          rows_cleared;
   logic [15:0]                         lines_total;
   logic [19:0]                         score;

   modport master (
      output start, map_in,
      input  busy, done, map_out, rows_cleared, lines_total, score
   );

   modport slave (
      input  start, map_in,
      output busy, done, map_out, rows_cleared, lines_total, score
   );
endinterface

// File: rtl/line_clear_engine.sv
// Line clear engine: scans a playfield snapshot bottom-up one row per cycle,
// removes each full row by shifting everything above it down one row per
// cycle, then reports the number of rows removed and updates the running
// line count and score (both saturating).
module line_clear_engine #(
   parameter int ROWS = 20,
   parameter int COLS = 10,
   parameter int CW   = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic reset_game,
   line_clear_engine_if.slave bus
);

   localparam int IW = $clog2(ROWS);
   localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SCAN,
      SHIFT,
      DONE
   } state_t;

   typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] map_t;

   state_t          state_reg;
   map_t            map_reg;
   logic [IW-1:0]   idx_reg;
   logic [IW-1:0]   ptr_reg;
   logic [4:0]      cnt_reg;
   logic            busy_reg;
   logic            done_reg;
   logic [2:0]      rows_cleared_reg;
   logic [15:0]     lines_reg;
   logic [19:0]     score_reg;

   logic            clear;
   logic [COLS-1:0] cell_used;
   logic            row_full;
   logic [19:0]     points;
   logic [20:0]     score_sum;
   logic [16:0]     lines_sum;
   logic [19:0]     score_next;
   logic [15:0]     lines_next;
   logic [2:0]      rows_cleared_next;

   assign clear = Reset | reset_game;

   // One occupancy flag per cell of the row currently under test.
   generate
      for (genvar gi = 0; gi < COLS; gi++) begin : g_cell
         assign cell_used[gi] = (map_reg[idx_reg][gi] != '0);
      end
   endgenerate

   assign row_full = &cell_used;

   // Points for the number of rows removed in one operation; more than four
   // is impossible with legal pieces and is scored like a tetris.
   always_comb begin
      points = 20'd0;
      case (cnt_reg)
         5'd0:    points = 20'd0;
         5'd1:    points = 20'd40;
         5'd2:    points = 20'd100;
         5'd3:    points = 20'd300;
         default: points = 20'd1200;
      endcase
   end

   // Widened adds so the carry out can be detected and clamped to full scale.
   always_comb begin
      score_sum         = {1'b0, score_reg} + {1'b0, points};
      lines_sum         = {1'b0, lines_reg} + {12'd0, cnt_reg};
      score_next        = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
      lines_next        = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
      rows_cleared_next = (cnt_reg > 5'd4) ? 3'd4 : cnt_reg[2:0];
   end

   // Control FSM with the working map and all result registers.
   always_ff @(posedge Clk) begin
      if (clear) begin
         state_reg        <= IDLE;
         map_reg          <= '0;
         idx_reg          <= '0;
         ptr_reg          <= '0;
         cnt_reg          <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         rows_cleared_reg <= '0;
         lines_reg        <= '0;
         score_reg        <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  busy_reg  <= 1'b1;
                  state_reg <= LOAD;
               end
            end
            LOAD: begin
               map_reg   <= bus.map_in;
               idx_reg   <= LAST_ROW;
               cnt_reg   <= '0;
               busy_reg  <= 1'b1;
               state_reg <= SCAN;
            end
            SCAN: begin
               if (row_full) begin
                  ptr_reg   <= idx_reg;
                  state_reg <= SHIFT;
               end else if (idx_reg != '0) begin
                  idx_reg <= idx_reg - 1'b1;
               end else begin
                  state_reg <= DONE;
               end
            end
            SHIFT: begin
               // idx stays put so a row that drops into it is tested again.
               if (ptr_reg != '0) begin
                  map_reg[ptr_reg] <= map_reg[ptr_reg - 1'b1];
                  ptr_reg          <= ptr_reg - 1'b1;
               end else begin
                  map_reg[0] <= '0;
                  cnt_reg    <= cnt_reg + 5'd1;
                  state_reg  <= SCAN;
               end
            end
            DONE: begin
               done_reg         <= 1'b1;
               busy_reg         <= 1'b0;
               rows_cleared_reg <= rows_cleared_next;
               lines_reg        <= lines_next;
               score_reg        <= score_next;
               state_reg        <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = busy_reg;
   assign bus.done         = done_reg;
   assign bus.map_out      = map_reg;
   assign bus.rows_cleared = rows_cleared_reg;
   assign bus.lines_total  = lines_reg;
   assign bus.score        = score_reg;

endmodule

// File: tb/tb_line_clear_engine.sv
// Testbench for line_clear_engine: directed scenarios plus random playfields,
// checked against a compaction model of the playfield.
module tb_line_clear_engine;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int CW   = 4;
   localparam int MW   = ROWS * COLS * CW;

   typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] map_t;

   logic Clk;
   logic Reset;
   logic reset_game;

   line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus ();

   line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .reset_game (reset_game),
      .bus        (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;

   // Running totals the bench expects the DUT to hold.
   longint exp_lines = 0;
   longint exp_score = 0;

   task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pts(input int n);
      case (n)
         0:       return 0;
         1:       return 40;
         2:       return 100;
         3:       return 300;
         default: return 1200;
      endcase
   endfunction

   // Full rows vanish, remaining rows keep their order and settle at the
   // bottom. A full original row j with c clears below it is found at index
   // j+c and costs one shift per row from there up to row 0, plus a rescan.
   function automatic void model(input map_t m, output map_t res, output int cnt, output int lat);
      int w;
      bit full;
      res = '0;
      w   = ROWS - 1;
      cnt = 0;
      lat = ROWS + 2;
      for (int j = ROWS - 1; j >= 0; j--) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++)
            if (m[j][c] == 0) full = 1'b0;
         if (full) begin
            lat += (j + cnt) + 2;
            cnt++;
         end else begin
            res[w] = m[j];
            w--;
         end
      end
   endfunction

   // Run one operation; optionally pulse start again while busy.
   task automatic run_op(input string name, input map_t m, input bit second_start);
      map_t exp_map, got_map;
      int   cnt, lat, n, dones, got_lat;
      bit   got;
      logic [2:0]  got_rc;
      logic [15:0] got_lines;
      logic [19:0] got_score;
      logic        got_busy;
      model(m, exp_map, cnt, lat);
      exp_lines = (exp_lines + cnt > 64'hFFFF) ? 64'hFFFF : exp_lines + cnt;
      exp_score = (exp_score + pts(cnt) > 64'hFFFFF) ? 64'hFFFFF : exp_score + pts(cnt);

      @(negedge Clk);
      bus.map_in = m;
      bus.start  = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      chk({name, " busy_after_start"}, MW'(bus.busy), MW'(1'b1));
      n = 0; dones = 0; got = 1'b0; got_lat = 0;
      got_map = '0; got_rc = '0; got_lines = '0; got_score = '0; got_busy = 1'b1;
      while (n < 700 && !(got && n >= got_lat + 30)) begin
         if (second_start && n == 5) bus.start = 1'b1;
         @(posedge Clk);
         #1;
         bus.start = 1'b0;
         n++;
         if (bus.done === 1'b1) begin
            dones++;
            if (!got) begin
               got       = 1'b1;
               got_lat   = n;
               got_map   = bus.map_out;
               got_rc    = bus.rows_cleared;
               got_lines = bus.lines_total;
               got_score = bus.score;
               got_busy  = bus.busy;
            end
         end
      end
      chk({name, " done_seen"}, MW'(got), MW'(1'b1));
      chk({name, " latency"}, MW'(got_lat), MW'(lat));
      chk({name, " map_out"}, MW'(got_map), MW'(exp_map));
      chk({name, " rows_cleared"}, MW'(got_rc), MW'((cnt > 4) ? 4 : cnt));
      chk({name, " lines_total"}, MW'(got_lines), MW'(exp_lines));
      chk({name, " score"}, MW'(got_score), MW'(exp_score));
      chk({name, " busy_at_done"}, MW'(got_busy), MW'(1'b0));
      chk({name, " done_count"}, MW'(dones), MW'(1));
      chk({name, " map_hold"}, MW'(bus.map_out), MW'(exp_map));
      $display("op %s: cleared=%0d latency=%0d score=%0d lines=%0d", name, cnt, got_lat, bus.score, bus.lines_total);
   endtask

   function automatic map_t full_row_map(input int lo, input int hi);
      map_t m = '0;
      for (int r = lo; r <= hi; r++)
         for (int c = 0; c < COLS; c++) m[r][c] = 4'(1 + ((r + c) % 15));
      return m;
   endfunction

   function automatic map_t random_map();
      map_t m = '0;
      int kind;
      for (int r = 0; r < ROWS; r++) begin
         kind = int'($urandom_range(0, 3));
         if (kind == 0) begin
            for (int c = 0; c < COLS; c++) m[r][c] = 4'($urandom_range(1, 15));
         end else if (kind >= 2) begin
            for (int c = 0; c < COLS; c++)
               m[r][c] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            m[r][$urandom_range(0, COLS - 1)] = 4'd0;
         end
      end
      return m;
   endfunction

   initial begin
      map_t m;
      int   n, dones;

      Reset = 1'b1; reset_game = 1'b0;
      bus.start = 1'b0; bus.map_in = '0;
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;
      chk("reset busy", MW'(bus.busy), MW'(1'b0));
      chk("reset done", MW'(bus.done), MW'(1'b0));
      chk("reset map_out", MW'(bus.map_out), MW'(0));
      chk("reset rows_cleared", MW'(bus.rows_cleared), MW'(0));
      chk("reset lines_total", MW'(bus.lines_total), MW'(0));
      chk("reset score", MW'(bus.score), MW'(0));

      // Empty map
      run_op("empty", '0, 1'b0);

      // Single full row with one block above it
      m = '0;
      for (int c = 0; c < COLS; c++) m[19][c] = 4'd3;
      m[18][0] = 4'd1;
      run_op("single", m, 1'b0);

      // Tetris on the bottom four rows
      run_op("tetris", full_row_map(16, 19), 1'b0);

      // Two full rows with a partial row between them
      m = full_row_map(17, 19);
      m[18] = '0;
      m[18][5] = 4'd2;
      run_op("split_pair", m, 1'b0);

      // Every row full
      run_op("all_full", full_row_map(0, ROWS - 1), 1'b0);

      // Reset while shifting
      m = full_row_map(19, 19);
      m[10][3] = 4'd7;
      @(negedge Clk);
      bus.map_in = m;
      bus.start  = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      exp_lines = 0;
      exp_score = 0;
      chk("midreset busy", MW'(bus.busy), MW'(1'b0));
      chk("midreset map_out", MW'(bus.map_out), MW'(0));
      chk("midreset score", MW'(bus.score), MW'(0));
      chk("midreset lines_total", MW'(bus.lines_total), MW'(0));
      dones = 0;
      for (n = 0; n < 40; n++) begin
         @(posedge Clk);
         #1;
         if (bus.done === 1'b1) dones++;
      end
      chk("midreset no_done", MW'(dones), MW'(0));
      $display("op midreset: done pulses after reset=%0d", dones);
      run_op("after_reset", m, 1'b0);

      // Extra start while busy, with the score just below full scale
      @(negedge Clk);
      dut.score_reg = 20'hFFFF0;
      exp_score = 64'hFFFF0;
      run_op("saturate", full_row_map(19, 19), 1'b1);

      // Random playfields
      for (int t = 0; t < 8; t++) begin
         run_op($sformatf("random%0d", t), random_map(), (t % 3) == 1);
      end

      // reset_game clears the running totals like Reset
      @(negedge Clk);
      reset_game = 1'b1;
      @(posedge Clk);
      #1;
      reset_game = 1'b0;
      exp_lines = 0;
      exp_score = 0;
      chk("reset_game score", MW'(bus.score), MW'(0));
      chk("reset_game lines_total", MW'(bus.lines_total), MW'(0));
      chk("reset_game map_out", MW'(bus.map_out), MW'(0));
      $display("op reset_game: score=%0d lines=%0d", bus.score, bus.lines_total);
      run_op("post_game", full_row_map(18, 19), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
